fsm_seq_ctrl: RTL
=================

// Module: fsm_seq_ctrl
//
// PURPOSE
//  Shares one bit-serial pattern detector (det_rst/det_din/det_dout) between NREQ requesters.
//  - Each requester submits a WIDTH-bit word.
//  - A round-robin arbiter grants one requester at a time.
//  - The controller resets and primes the detector, then shifts the word MSB-first into it.
//  - It counts det_dout hits and returns the count, tagged with the requester id.
//  - Sits between the client ports and the detector instance; the only block that drives the detector.
//
// PARAMETERS
//  NREQ   default 4   number of requesters, >=2
//  WIDTH  default 8   bits per word, >=2
//  IW     localparam  $clog2(NREQ), requester id width
//  CW     localparam  $clog2(WIDTH+1), hit-count width
//
// PORTS
//  clk        in   1           clock; all state on rising edge
//  rst        in   1           asynchronous, active-low reset
//  req_valid  in   NREQ        per-requester word valid
//  req_ready  out  NREQ        one-hot grant/accept, combinational
//  req_data   in   NREQ*WIDTH  word i at [i*WIDTH +: WIDTH]
//  det_rst    out  1           detector reset, active-high
//  det_din    out  1           serial bit to detector
//  det_dout   in   1           detector hit (Mealy, same-cycle as det_din)
//  rsp_valid  out  1           result valid
//  rsp_ready  in   1           result accepted
//  rsp_id     out  IW          requester index of result
//  rsp_count  out  CW          number of det_dout hits during the word
//
// BEHAVIOUR
//  Reset (rst low, async):
//  - state=IDLE, rr pointer=0, shift reg=0, bit counter=0, hit counter=0.
//  - Outputs: req_ready=0, det_rst=1, det_din=0, rsp_valid=0, rsp_id=0, rsp_count=0.
//  - Mid-operation reset abandons the word and drops any pending response; no partial result is issued.
//  States IDLE -> PRIME -> SHIFT -> RESP -> IDLE:
//  - IDLE:
//    - det_rst=1, det_din=0.
//    - req_ready = one-hot first valid requester at or after rr pointer, wrapping NREQ-1 -> 0; all 0 if none valid.
//    - Accept when req_valid[i]&req_ready[i]: latch word and id=i, set rr pointer=(i+1)%NREQ, clear hit counter, go PRIME.
//  - PRIME: one cycle, det_rst=0, det_din=0 (detector leaves idle); go SHIFT.
//  - SHIFT: WIDTH cycles, det_rst=0, det_din=shift reg MSB, shift left each cycle.
//    - Hit counter += det_dout each SHIFT cycle.
//    - After the WIDTH-th bit, go RESP.
//  - RESP:
//    - det_rst=1, rsp_valid=1; rsp_id/rsp_count stable until rsp_ready.
//    - On rsp_ready go IDLE; no new acceptance in the same cycle.
//  - req_ready=0 in all states except IDLE.
//  - det_dout is ignored outside SHIFT.
//  Timing and widths:
//  - Latency: acceptance edge at cycle 0 -> rsp_valid high at cycle WIDTH+2.
//  - With rsp_ready tied 1, minimum spacing is WIDTH+3 cycles per word.
//  - Hit counter never overflows (max WIDTH fits CW).
//  Boundary cases:
//  - req_valid deasserted without acceptance is legal; no grant is lost.
//  - Requester that won keeps lowest priority on the next arbitration.
//
// CONFIGURATION
//  FSM_SEQ_STAT_EN defined:
//  - Adds outputs stat_words[15:0] and stat_hits[15:0].
//  - stat_words increments on each RESP handshake; stat_hits adds rsp_count on the same handshake.
//  - Both saturate at 16'hFFFF and reset to 0 on rst low.
//  FSM_SEQ_STAT_EN undefined: ports and logic absent; behaviour otherwise identical.
//
// TESTING
//  (bench stubs detector: drives det_dout directly, checks det_rst/det_din)
//  1. Reset, then only req_valid[2], data 8'hB4
//     -> req_ready=4'b0100 next IDLE cycle; det_din over SHIFT = 1,0,1,1,0,1,0,0;
//        rsp_valid at cycle 10; rsp_id=2.
//  2. det_dout=1 on SHIFT cycles 2,3,7, also high in PRIME/RESP
//     -> rsp_count=3 (outside-SHIFT hits ignored).
//  3. req_valid=4'b1111 held, rsp_ready=1 -> grants 0,1,2,3,0 in order, spaced 11 cycles apart.
//  4. rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_count stable, req_ready=0, det_rst=1 throughout.
//  5. rst low during SHIFT bit 4
//     -> immediately det_rst=1, rsp_valid=0, req_ready=0; after release, rr pointer=0 and no response for the lost word.
//  6. FSM_SEQ_STAT_EN: 3 words with counts 3,0,8 -> stat_words=3, stat_hits=11.

Source files
------------

// File: rtl/fsm_seq_ctrl_if.sv
// fsm_seq_ctrl_if: request/response bus between requesters and the shared-detector controller
//   req_valid/req_ready/req_data : per-requester word submission, word i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready          : result handshake
//   rsp_id/rsp_count             : requester index and hit count of the result
//   master = requester side, slave = controller side
interface fsm_seq_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [CW-1:0]         rsp_count;
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_count
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_count
    );
endinterface

// File: rtl/fsm_seq_ctrl.sv
// fsm_seq_ctrl: round-robin shares one bit-serial pattern detector between NREQ requesters
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : fsm_seq_ctrl_if.slave, request and response handshakes
//   det_rst   : detector reset, active-high
//   det_din   : serial bit to the detector, word sent MSB-first
//   det_dout  : detector hit, sampled only while shifting
//   stat_words/stat_hits : saturating statistics, present only with FSM_SEQ_STAT_EN defined
module fsm_seq_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    fsm_seq_ctrl_if.slave       bus,
    output logic                det_rst,
    output logic                det_din,
    input  logic                det_dout
`ifdef FSM_SEQ_STAT_EN
    ,
    output logic [15:0]         stat_words,
    output logic [15:0]         stat_hits
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRIME = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    logic [1:0]       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    id;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bcnt;
    logic [CW-1:0]    hits;
    logic [IW-1:0]    gnt_id;
    logic             found;
    // first valid requester at or after ptr, wrapping
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                gnt_id = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end
    // rst gating keeps req_ready low while reset is held even though state reads IDLE
    wire accept = rst && state == IDLE && found;
    assign bus.req_ready = accept ? NREQ'(1) << gnt_id : '0;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_id    = id;
    assign bus.rsp_count = hits;
    assign det_rst       = state == IDLE || state == RESP;
    assign det_din       = state == SHIFT && sreg[WIDTH-1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            sreg  <= '0;
            bcnt  <= '0;
            hits  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    sreg  <= bus.req_data[int'(gnt_id)*WIDTH +: WIDTH];
                    id    <= gnt_id;
                    ptr   <= gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
                    hits  <= '0;
                    state <= PRIME;
                end
                PRIME: begin
                    bcnt  <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    sreg  <= sreg << 1;
                    hits  <= hits + CW'(det_dout);
                    bcnt  <= bcnt + 1'b1;
                    state <= bcnt == CW'(WIDTH - 1) ? RESP : SHIFT;
                end
                default: state <= bus.rsp_ready ? IDLE : RESP;
            endcase
        end
    end
`ifdef FSM_SEQ_STAT_EN
    wire [16:0] hit_sum = {1'b0, stat_hits} + 17'(hits);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_words <= '0;
            stat_hits  <= '0;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            stat_words <= &stat_words ? stat_words : stat_words + 1'b1;
            stat_hits  <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
        end
    end
`endif
endmodule
